// File: rtl/pipe_reg_pkg.sv
// Shared types and helpers for the pipe_reg_chain register pipeline.
package pipe_reg_pkg;

  localparam int DEF_WIDTH = 8;

  // Default stage record; the chain re-declares it at its own WIDTH.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// Upstream/downstream handshake bundle plus chain controls for pipe_reg_chain.
interface pipe_reg_if
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = occ_width(DEPTH);

  logic             enable;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occ;

  modport slave (
    input  enable, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );

  modport master (
    output enable, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: data register plus valid bit with load and clear controls.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter type stage_type = stage_t
) (
  input  logic      clk50M,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  stage_type d,
  output stage_type q
);

  // Data is only overwritten by a real word, so a drained stage keeps its last value.
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q.valid <= d.valid;
      if (d.valid) q.data <= d.data;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain with bubble collapse, freeze (enable high) and flush.
// Occupancy counter is built only when PIPE_REG_OCC_EN is defined.
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic        clk50M,
  input logic        rst,
  pipe_reg_if.slave  bus
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_w_t;

  stage_w_t         sd [DEPTH];
  stage_w_t         sq [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ld;
  logic [DEPTH:0]   rdy;
  logic             accept;

  // Ready ripples from the output back; it never looks at in_valid.
  always_comb begin
    rdy[DEPTH] = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = !vld[k] || rdy[k+1];
  end

  assign bus.in_ready = rst && rdy[0] && !bus.enable && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign sd[0]        = {accept, bus.in_data};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign sd[k] = sq[k-1];
    end
    assign vld[k] = sq[k].valid;
    assign ld[k]  = rdy[k] && !bus.enable;

    pipe_reg_stage #(.stage_type(stage_w_t)) u_stage (
      .clk50M (clk50M),
      .rst    (rst),
      .load   (ld[k]),
      .clear  (bus.flush),
      .d      (sd[k]),
      .q      (sq[k])
    );
  end

  assign bus.out_valid = vld[DEPTH-1] && !bus.enable && !bus.flush;
  assign bus.out_data  = sq[DEPTH-1].data;

`ifdef PIPE_REG_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;

  // Count the valid bits each stage will hold after this edge.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!bus.flush && (ld[k] ? sd[k].valid : vld[k])) occ_d = occ_d + OCC_W'(1);
    end
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign bus.occ = occ_q;
`else
  assign bus.occ = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=4) with a slot-level reference model.
module tb_pipe_reg_chain;
  import pipe_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef PIPE_REG_OCC_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  logic clk50M = 1'b0;
  logic rst    = 1'b0;
  always #10 clk50M = ~clk50M;

  pipe_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk50M (clk50M),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words oldest-first, each with its slot index (0..DEPTH-1).
  logic [WIDTH-1:0] mdata [$];
  int               mpos  [$];
  logic [WIDTH-1:0] got   [$];
  int               out_cyc [$];
  int               cyc   = 0;
  int               acc_n = 0;

  typedef struct {
    bit             iv;
    logic [7:0]     id;
    bit             ordy;
    bit             ov;
    logic [7:0]     od;
    bit             ir;
    int             occ;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    int np [$];
    int cap, p, first;
    bit fr, fl, ov, pop, ir;
    #5;
    fr    = bus.enable;
    fl    = bus.flush;
    ov    = !fr && !fl && (mpos.size() > 0) && (mpos[0] == DEPTH - 1);
    pop   = ov && bus.out_ready;
    first = pop ? 1 : 0;
    cap   = DEPTH - 1;
    for (int i = first; i < mpos.size(); i++) begin
      p = mpos[i] + 1;
      if (p > cap) p = cap;
      np.push_back(p);
      cap = p - 1;
    end
    ir = !fr && !fl && (np.size() == 0 || np[np.size()-1] >= 1);
    check("in_ready", 32'(bus.in_ready), 32'(ir));
    check("out_valid", 32'(bus.out_valid), 32'(ov));
    if (ov) check("out_data", 32'(bus.out_data), 32'(mdata[0]));
    check("occ", 32'(bus.occ), OCC_EN ? 32'(mdata.size()) : 32'd0);
    if (bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_data);
      out_cyc.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) acc_n++;
    @(posedge clk50M);
    if (fl) begin
      mdata.delete();
      mpos.delete();
    end else if (!fr) begin
      if (pop) void'(mdata.pop_front());
      mpos = np;
      if (ir && bus.in_valid) begin
        mdata.push_back(bus.in_data);
        mpos.push_back(0);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.enable    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, acc0, emit0, lat, acc_cyc;

    idle_inputs();
    #5;
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_data", 32'(bus.out_data), 32'd0);
    check("reset occ", 32'(bus.occ), 32'd0);
    @(posedge clk50M);
    #1;
    rst = 1'b1;

    // Streaming 0x11,0x22,0x33: words appear four cycles after they are presented.
    tbl[0] = '{1, 8'h11, 1, 0, 8'h00, 1, 0};
    tbl[1] = '{1, 8'h22, 1, 0, 8'h00, 1, 1};
    tbl[2] = '{1, 8'h33, 1, 0, 8'h00, 1, 2};
    tbl[3] = '{0, 8'h00, 1, 0, 8'h00, 1, 3};
    tbl[4] = '{0, 8'h00, 1, 1, 8'h11, 1, 3};
    tbl[5] = '{0, 8'h00, 1, 1, 8'h22, 1, 2};
    tbl[6] = '{0, 8'h00, 1, 1, 8'h33, 1, 1};
    tbl[7] = '{0, 8'h00, 1, 0, 8'h00, 1, 0};
    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = tbl[i].iv;
      bus.in_data   = tbl[i].id;
      bus.out_ready = tbl[i].ordy;
      #2;
      check("tbl in_ready", 32'(bus.in_ready), 32'(tbl[i].ir));
      check("tbl out_valid", 32'(bus.out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) check("tbl out_data", 32'(bus.out_data), 32'(tbl[i].od));
      check("tbl occ", 32'(bus.occ), OCC_EN ? 32'(tbl[i].occ) : 32'd0);
      cycle();
    end
    drain();

    // Backpressure: six offered words, only four fit.
    got.delete();
    acc0 = acc_n;
    bus.out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h40 + 8'(n);
      #1;
      if (bus.in_ready) n++;
      cycle();
    end
    check("bp accepted", 32'(acc_n - acc0), 32'd4);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("bp emitted", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) check("bp order", 32'(got[i]), 32'h40 + 32'(i));

    // Freeze with two words inside.
    got.delete();
    bus.in_valid = 1'b1; bus.in_data = 8'hA1; cycle();
    bus.in_data = 8'hA2; cycle();
    bus.in_data = 8'hEE; bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();
    check("freeze count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("freeze word0", 32'(got[0]), 32'hA1);
      check("freeze word1", 32'(got[1]), 32'hA2);
    end

    // Flush with three words and a competing input.
    got.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'h60 + 8'(i);
      cycle();
    end
    bus.flush = 1'b1; bus.in_data = 8'hAA;
    cycle();
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();
    check("flush emitted", 32'(got.size()), 32'd0);

    // Asynchronous reset between edges with two words in flight.
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_data = 8'h71; cycle();
    bus.in_data = 8'h72; cycle();
    #3;
    rst = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst out_data", 32'(bus.out_data), 32'd0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst occ", 32'(bus.occ), 32'd0);
    mdata.delete();
    mpos.delete();
    @(posedge clk50M);
    #1;
    rst = 1'b1;
    got.delete();
    out_cyc.delete();
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_data = 8'hC5;
    acc_cyc = cyc;
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    if (out_cyc.size() == 0) begin
      check("post-reset word seen", 32'd0, 32'd1);
    end else begin
      lat = out_cyc[0] - acc_cyc;
      check("post-reset latency", 32'(lat), 32'd4);
      check("post-reset word", 32'(got[0]), 32'hC5);
    end

    // Full throughput with a full chain.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h80 + 8'(i);
      cycle();
    end
    got.delete();
    acc0 = acc_n;
    emit0 = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 8'h90 + 8'(i);
      cycle();
    end
    emit0 = got.size();
    check("ft accepted", 32'(acc_n - acc0), 32'd10);
    check("ft emitted", 32'(emit0), 32'd10);
    if (emit0 >= 5) check("ft order", 32'(got[4]), 32'h90);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_data   = 8'($urandom);
      bus.out_ready = $urandom_range(0, 2) != 0;
      bus.enable    = $urandom_range(0, 7) == 0;
      bus.flush     = $urandom_range(0, 31) == 0;
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
